seq_counter_ctrl: RTL and testbench
===================================

// Module: seq_counter_ctrl
// PURPOSE
//  Run-control sequencer for a 4-bit JK-flip-flop sequence counter.
//  - Gates the counter's advance (cnt_en) and drives its synchronous clear (cnt_clear_n).
//  - Accepts RUN / STEP-n / STOP / RESTART commands over a valid/ready handshake.
//  - Counts sequence wraps and detects lock-out (illegal) states, recovering with a clear pulse.
// PARAMETERS
//  CW          8        width of cmd_count (STEP length)
//  WW          8        width of wrap_cnt
//  LEGAL_MASK  16'h03FF bit s = 1 -> counter state s is legal
//  LAST_STATE  4'd9     state whose advance counts as one wrap
// PORTS
//  clk          in   1   system clock, rising edge
//  clear        in   1   synchronous reset, active-low
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   command accepted at edge where cmd_valid & cmd_ready
//  cmd_op       in   2   00 STOP, 01 RUN, 10 STEP, 11 RESTART
//  cmd_count    in   CW  number of advances for STEP
//  cnt_q        in   4   current counter state
//  cnt_en       out  1   counter advances at every edge where high
//  cnt_clear_n  out  1   active-low synchronous clear to counter
//  busy         out  1   state is RUN, STEP or CLR
//  done         out  1   one-cycle completion pulse
//  wrap_cnt     out  WW  saturating count of LAST_STATE advances
//  err          out  1   sticky lock-out flag
//  err_state    out  4   cnt_q captured at first lock-out
// BEHAVIOUR
//  - legal = LEGAL_MASK[cnt_q].
//  - FSM states: IDLE, RUN, STEP, CLR. State, done, wrap_cnt, err, err_state and remaining are registered.
//  - clear=0: state=IDLE; done, wrap_cnt, err, err_state and remaining all 0.
//  - While clear=0: cnt_clear_n=0, cmd_ready=0, cnt_en=0.
//  - Combinational outputs:
//    cnt_en      = (RUN|STEP) & legal
//    cnt_clear_n = clear & (state!=CLR)
//    cmd_ready   = clear & (IDLE|RUN) & legal
//  - IDLE, on accept:
//    RUN -> RUN
//    STEP, count=0 -> stay IDLE, done=1 next cycle
//    STEP, count=n -> STEP, remaining=n
//    RESTART -> err=0, err_state=0, wrap_cnt=0, go CLR
//    STOP -> no effect
//  - RUN, on accept:
//    STOP -> IDLE; cnt_en is still high in the accepting cycle
//    RESTART -> as in IDLE
//    RUN, STEP -> accepted and discarded
//  - STEP: cnt_en high for exactly n cycles; remaining decrements per cycle.
//    On the cycle remaining=1 -> IDLE, done=1 in the following cycle. cmd_ready=0 throughout.
//  - CLR: lasts exactly one cycle (cnt_clear_n=0), then IDLE.
//    done=1 in the IDLE cycle only if CLR was entered via RESTART.
//  - Latency: command accepted at edge E -> first cnt_en cycle immediately after E.
//  - Wrap: at any edge with cnt_en=1 and cnt_q=LAST_STATE, wrap_cnt+=1; saturates at all-ones.
//  - Lock-out check is active in IDLE, RUN, STEP. If !legal:
//    cnt_en=0 and cmd_ready=0 that cycle; next edge sets err=1.
//    err_state=cnt_q only if err was 0; state -> CLR; STEP aborts with no done.
//    Lock-out wins over any simultaneous command. err clears only via RESTART or reset.
//  - Reset asserted mid-STEP/RUN: immediate IDLE at the next edge; counter cleared via cnt_clear_n.
// TESTING (bench models counter as decade 0..9; illegal states forced directly)
//  1. clear=0 for 2 cycles -> cnt_clear_n=0, cmd_ready=0, all regs 0;
//     after release cmd_ready=1, busy=0.
//  2. cnt_q=0, STEP 5 -> cnt_en high 5 cycles, cnt_q=5, single done pulse, cmd_ready=0 during STEP.
//  3. RUN, then STOP accepted on the 25th RUN cycle -> 25 advances, cnt_q=5, wrap_cnt=2, no done.
//  4. STEP 0 -> done next cycle, cnt_en never high.
//  5. IDLE, force cnt_q=4'hC -> cnt_en=0, cmd_ready=0; next cycle err=1, err_state=C,
//     cnt_clear_n=0 one cycle, no done.
//     Then RESTART -> err=0, wrap_cnt=0, clear pulse, done.
//  6. Mid-STEP 8 (after 3 advances), force cnt_q=4'hA -> STEP aborts, err=1, err_state=A,
//     no done; STOP offered during STEP is never accepted.

Source files
------------

// File: rtl/seq_counter_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_counter_ctrl_if
// Command channel of the sequence-counter run controller.
//   cmd_valid  master -> slave  command present
//   cmd_ready  slave -> master  command taken at an edge where valid & ready
//   cmd_op     master -> slave  00 STOP, 01 RUN, 10 STEP, 11 RESTART
//   cmd_count  master -> slave  number of advances for STEP
// -----------------------------------------------------------------------------
interface seq_counter_ctrl_if #(
   parameter int unsigned CW = 8
) ();
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [CW-1:0] cmd_count;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_count,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_count,
      output cmd_ready
   );
endinterface

// File: rtl/seq_counter_ctrl.sv
// -----------------------------------------------------------------------------
// seq_counter_ctrl
// Run-control sequencer for a 4-bit sequence counter: gates the counter's
// advance, drives its synchronous clear, executes RUN / STEP-n / STOP /
// RESTART commands, counts sequence wraps and recovers from lock-out states.
// Ports:
//   i_clk          system clock, rising edge
//   i_clear        synchronous reset, active-low
//   cmd_if         command channel (slave side)
//   i_cnt_q        current counter state
//   o_cnt_en       counter advances at every edge where high
//   o_cnt_clear_n  active-low synchronous clear to the counter
//   o_busy         controller is in RUN, STEP or CLR
//   o_done         one-cycle completion pulse
//   o_wrap_cnt     saturating count of LAST_STATE advances
//   o_err          sticky lock-out flag
//   o_err_state    counter state captured at the first lock-out
// -----------------------------------------------------------------------------
module seq_counter_ctrl #(
   parameter int unsigned CW         = 8,
   parameter int unsigned WW         = 8,
   parameter logic [15:0] LEGAL_MASK = 16'h03FF,
   parameter logic [3:0]  LAST_STATE = 4'd9
) (
   input  logic                i_clk,
   input  logic                i_clear,
   seq_counter_ctrl_if.slave   cmd_if,
   input  logic [3:0]          i_cnt_q,
   output logic                o_cnt_en,
   output logic                o_cnt_clear_n,
   output logic                o_busy,
   output logic                o_done,
   output logic [WW-1:0]       o_wrap_cnt,
   output logic                o_err,
   output logic [3:0]          o_err_state
);

   typedef enum logic [1:0] {StIdle, StRun, StStep, StClr} state_e;

   localparam logic [1:0] OpStop    = 2'b00;
   localparam logic [1:0] OpRun     = 2'b01;
   localparam logic [1:0] OpStep    = 2'b10;
   localparam logic [1:0] OpRestart = 2'b11;

   state_e        r_state,       w_state_d;
   logic [CW-1:0] r_remaining,   w_remaining_d;
   logic          r_done,        w_done_d;
   logic [WW-1:0] r_wrap_cnt,    w_wrap_cnt_d;
   logic          r_err,         w_err_d;
   logic [3:0]    r_err_state,   w_err_state_d;
   // Remembers whether CLR was entered by RESTART (done) or by lock-out (no done).
   logic          r_clr_restart, w_clr_restart_d;

   logic w_legal;
   logic w_lockout;
   logic w_ready;
   logic w_accept;

   assign w_legal   = LEGAL_MASK[i_cnt_q];
   // Lock-out is only checked outside CLR; CLR itself is the recovery cycle.
   assign w_lockout = (r_state != StClr) && !w_legal;
   assign w_accept  = cmd_if.cmd_valid && w_ready;

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_clear) begin
         r_state       <= StIdle;
         r_remaining   <= '0;
         r_done        <= 1'b0;
         r_wrap_cnt    <= '0;
         r_err         <= 1'b0;
         r_err_state   <= 4'd0;
         r_clr_restart <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_remaining   <= w_remaining_d;
         r_done        <= w_done_d;
         r_wrap_cnt    <= w_wrap_cnt_d;
         r_err         <= w_err_d;
         r_err_state   <= w_err_state_d;
         r_clr_restart <= w_clr_restart_d;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_d       = r_state;
      w_remaining_d   = r_remaining;
      w_done_d        = 1'b0;
      w_wrap_cnt_d    = r_wrap_cnt;
      w_err_d         = r_err;
      w_err_state_d   = r_err_state;
      w_clr_restart_d = r_clr_restart;

      if (o_cnt_en && (i_cnt_q == LAST_STATE) && (r_wrap_cnt != '1)) begin
         w_wrap_cnt_d = r_wrap_cnt + WW'(1);
      end

      if (w_lockout) begin
         // Lock-out overrides any command offered in the same cycle.
         w_state_d       = StClr;
         w_clr_restart_d = 1'b0;
         w_err_d         = 1'b1;
         if (!r_err) begin
            w_err_state_d = i_cnt_q;
         end
      end else begin
         unique case (r_state)
            StIdle, StRun: begin
               if (w_accept) begin
                  case (cmd_if.cmd_op)
                     OpStop: begin
                        w_state_d = StIdle;
                     end
                     OpRun: begin
                        w_state_d = StRun;
                     end
                     OpStep: begin
                        // STEP while running is discarded.
                        if (r_state == StIdle) begin
                           if (cmd_if.cmd_count == '0) begin
                              w_done_d = 1'b1;
                           end else begin
                              w_state_d     = StStep;
                              w_remaining_d = cmd_if.cmd_count;
                           end
                        end
                     end
                     OpRestart: begin
                        w_state_d       = StClr;
                        w_clr_restart_d = 1'b1;
                        w_err_d         = 1'b0;
                        w_err_state_d   = 4'd0;
                        w_wrap_cnt_d    = '0;
                     end
                  endcase
               end
            end
            StStep: begin
               w_remaining_d = r_remaining - CW'(1);
               if (r_remaining == CW'(1)) begin
                  w_state_d = StIdle;
                  w_done_d  = 1'b1;
               end
            end
            StClr: begin
               w_state_d = StIdle;
               w_done_d  = r_clr_restart;
            end
         endcase
      end
   end

   // Outputs
   always_comb begin
      o_cnt_en      = i_clear && w_legal && ((r_state == StRun) || (r_state == StStep));
      o_cnt_clear_n = i_clear && (r_state != StClr);
      w_ready       = i_clear && w_legal && ((r_state == StIdle) || (r_state == StRun));
      o_busy        = (r_state != StIdle);
   end

   assign cmd_if.cmd_ready = w_ready;
   assign o_done           = r_done;
   assign o_wrap_cnt       = r_wrap_cnt;
   assign o_err            = r_err;
   assign o_err_state      = r_err_state;

endmodule

// File: tb/tb_seq_counter_ctrl.sv
module tb_seq_counter_ctrl;

   localparam int OP_STOP    = 0;
   localparam int OP_RUN     = 1;
   localparam int OP_STEP    = 2;
   localparam int OP_RESTART = 3;
   localparam int WRAP_MAX   = 255;

   typedef struct {
      int op;
      int n;
      int adv;
      int q;
      int wrap;
      int dn;
   } vec_t;

   logic       clk = 1'b0;
   logic       clear;
   logic [3:0] r_ctr = 4'd0;
   logic       force_en = 1'b0;
   logic [3:0] force_val = 4'd0;
   wire  [3:0] w_cnt_q = force_en ? force_val : r_ctr;

   logic       cnt_en, cnt_clear_n, busy, done, err;
   logic [7:0] wrap_cnt;
   logic [3:0] err_state;

   int n_total = 0;
   int n_bad   = 0;
   int mon_en, mon_done, mon_clr, step_rdy;
   int exp_q, exp_wrap;

   seq_counter_ctrl_if #(.CW(8)) u_if ();

   seq_counter_ctrl u_dut (
      .i_clk         (clk),
      .i_clear       (clear),
      .cmd_if        (u_if),
      .i_cnt_q       (w_cnt_q),
      .o_cnt_en      (cnt_en),
      .o_cnt_clear_n (cnt_clear_n),
      .o_busy        (busy),
      .o_done        (done),
      .o_wrap_cnt    (wrap_cnt),
      .o_err         (err),
      .o_err_state   (err_state)
   );

   always #5 clk = ~clk;

   // Decade counter driven by the DUT's enable and clear.
   always @(posedge clk) begin
      if (!cnt_clear_n)     r_ctr <= 4'd0;
      else if (cnt_en)      r_ctr <= (r_ctr == 4'd9) ? 4'd0 : r_ctr + 4'd1;
   end

   // Per-cycle activity counters, sampled mid-low-phase.
   always @(negedge clk) begin
      #2;
      if (cnt_en)       mon_en++;
      if (done)         mon_done++;
      if (!cnt_clear_n) mon_clr++;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Offer a command (called at a falling edge) and hold it until accepted.
   task automatic send(input int op, input int cnt);
      int guard;
      guard = 0;
      u_if.cmd_valid = 1'b1;
      u_if.cmd_op    = op[1:0];
      u_if.cmd_count = cnt[7:0];
      #1;
      while (!u_if.cmd_ready && guard < 50) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (guard >= 50) begin
         n_total++;
         n_bad++;
         $display("FAIL send_timeout: got ready=0 expected ready=1 (op %0d)", op);
      end
      @(posedge clk);
      @(negedge clk);
      u_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input bit is_step);
      int guard;
      guard = 0;
      while (busy && guard < 5000) begin
         if (is_step && u_if.cmd_ready) step_rdy++;
         @(negedge clk);
         guard++;
      end
      if (guard >= 5000) begin
         n_total++;
         n_bad++;
         $display("FAIL idle_timeout: got busy=1 expected busy=0");
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic run_txn(input int op, input int n, output int adv, output int dn);
      mon_en   = 0;
      mon_done = 0;
      mon_clr  = 0;
      step_rdy = 0;
      case (op)
         OP_STOP: begin
            send(OP_STOP, 0);
            repeat (2) @(negedge clk);
         end
         OP_RUN: begin
            send(OP_RUN, 0);
            repeat (n - 1) @(negedge clk);
            send(OP_STOP, 0);
            wait_idle(1'b0);
         end
         OP_STEP: begin
            send(OP_STEP, n);
            wait_idle(1'b1);
         end
         default: begin
            send(OP_RESTART, 0);
            wait_idle(1'b0);
         end
      endcase
      adv = mon_en;
      dn  = mon_done;
   endtask

   // Reference: advances/done per command, counter and wraps by arithmetic.
   task automatic model_txn(input int op, input int n, output int adv, output int dn);
      case (op)
         OP_STOP:    begin adv = 0; dn = 0; end
         OP_RUN:     begin adv = n; dn = 0; end
         OP_STEP:    begin adv = n; dn = 1; end
         default:    begin adv = 0; dn = 1; end
      endcase
      if (op == OP_RESTART) begin
         exp_q    = 0;
         exp_wrap = 0;
      end else begin
         exp_wrap = exp_wrap + (exp_q + adv) / 10;
         if (exp_wrap > WRAP_MAX) exp_wrap = WRAP_MAX;
         exp_q = (exp_q + adv) % 10;
      end
   endtask

   initial begin
      vec_t tbl[6];
      int   adv, dn, e_adv, e_dn, rdy_seen;

      tbl[0] = '{OP_RUN,  25, 25, 5, 2, 0};
      tbl[1] = '{OP_STEP,  5,  5, 0, 3, 1};
      tbl[2] = '{OP_STEP,  0,  0, 0, 3, 1};
      tbl[3] = '{OP_STOP,  0,  0, 0, 3, 0};
      tbl[4] = '{OP_STEP, 19, 19, 9, 4, 1};
      tbl[5] = '{OP_RUN,   1,  1, 0, 5, 0};

      // Reset with a command offered
      clear          = 1'b0;
      u_if.cmd_valid = 1'b1;
      u_if.cmd_op    = 2'b01;
      u_if.cmd_count = 8'd0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_clear_n", cnt_clear_n, 0);
      chk("rst_ready", u_if.cmd_ready, 0);
      chk("rst_cnt_en", cnt_en, 0);
      chk("rst_done", done, 0);
      chk("rst_wrap", wrap_cnt, 0);
      chk("rst_err", err, 0);
      chk("rst_err_state", err_state, 0);
      chk("rst_busy", busy, 0);
      u_if.cmd_valid = 1'b0;
      clear          = 1'b1;
      #1;
      chk("rel_ready", u_if.cmd_ready, 1);
      chk("rel_busy", busy, 0);
      chk("rel_clear_n", cnt_clear_n, 1);
      @(negedge clk);

      // Table of command transactions from a cleared counter
      for (int i = 0; i < 6; i++) begin
         run_txn(tbl[i].op, tbl[i].n, adv, dn);
         chk($sformatf("tbl%0d_adv", i), adv, tbl[i].adv);
         chk($sformatf("tbl%0d_q", i), w_cnt_q, tbl[i].q);
         chk($sformatf("tbl%0d_wrap", i), wrap_cnt, tbl[i].wrap);
         chk($sformatf("tbl%0d_done", i), dn, tbl[i].dn);
         if (tbl[i].op == OP_STEP) chk($sformatf("tbl%0d_step_ready", i), step_rdy, 0);
      end
      exp_q    = 0;
      exp_wrap = 5;

      // Lock-out while idle
      mon_done  = 0;
      mon_clr   = 0;
      force_val = 4'hC;
      force_en  = 1'b1;
      #1;
      chk("lk_idle_en", cnt_en, 0);
      chk("lk_idle_ready", u_if.cmd_ready, 0);
      @(negedge clk);
      #1;
      chk("lk_idle_err", err, 1);
      chk("lk_idle_err_state", err_state, 12);
      chk("lk_idle_clear_n", cnt_clear_n, 0);
      force_en = 1'b0;
      @(negedge clk);
      #1;
      chk("lk_idle_clear_n_back", cnt_clear_n, 1);
      chk("lk_idle_busy", busy, 0);
      @(negedge clk);
      chk("lk_idle_done", mon_done, 0);
      chk("lk_idle_clr_cycles", mon_clr, 1);
      chk("lk_idle_q", w_cnt_q, 0);

      // RESTART clears err and wraps, one clear pulse, done
      run_txn(OP_RESTART, 0, adv, dn);
      model_txn(OP_RESTART, 0, e_adv, e_dn);
      chk("rs_done", dn, e_dn);
      chk("rs_clr_cycles", mon_clr, 1);
      chk("rs_err", err, 0);
      chk("rs_err_state", err_state, 0);
      chk("rs_wrap", wrap_cnt, exp_wrap);

      // Lock-out mid-STEP 8 after 3 advances, STOP offered throughout
      mon_en   = 0;
      mon_done = 0;
      rdy_seen = 0;
      send(OP_STEP, 8);
      u_if.cmd_valid = 1'b1;
      u_if.cmd_op    = 2'b00;
      repeat (3) begin
         #1;
         if (u_if.cmd_ready) rdy_seen++;
         @(negedge clk);
      end
      force_val = 4'hA;
      force_en  = 1'b1;
      #1;
      if (u_if.cmd_ready) rdy_seen++;
      chk("lk_step_en", cnt_en, 0);
      @(negedge clk);
      #1;
      chk("lk_step_err", err, 1);
      chk("lk_step_err_state", err_state, 10);
      chk("lk_step_busy_clr", busy, 1);
      force_en       = 1'b0;
      u_if.cmd_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("lk_step_idle", busy, 0);
      @(negedge clk);
      chk("lk_step_adv", mon_en, 3);
      chk("lk_step_done", mon_done, 0);
      chk("lk_step_stop_ready", rdy_seen, 0);
      chk("lk_step_q", w_cnt_q, 0);

      // Second lock-out keeps the first captured state
      force_val = 4'hF;
      force_en  = 1'b1;
      @(negedge clk);
      #1;
      chk("lk_sticky_err", err, 1);
      chk("lk_sticky_err_state", err_state, 10);
      force_en = 1'b0;
      repeat (2) @(negedge clk);
      run_txn(OP_RESTART, 0, adv, dn);
      model_txn(OP_RESTART, 0, e_adv, e_dn);
      chk("rs2_done", dn, e_dn);
      chk("rs2_err", err, 0);

      // Wrap counter saturation
      run_txn(OP_RUN, 2600, adv, dn);
      model_txn(OP_RUN, 2600, e_adv, e_dn);
      chk("sat_adv", adv, e_adv);
      chk("sat_wrap", wrap_cnt, exp_wrap);
      chk("sat_q", w_cnt_q, exp_q);

      // Reset asserted mid-RUN
      send(OP_RUN, 0);
      repeat (2) @(negedge clk);
      clear = 1'b0;
      #1;
      chk("mrst_en", cnt_en, 0);
      chk("mrst_clear_n", cnt_clear_n, 0);
      chk("mrst_ready", u_if.cmd_ready, 0);
      @(negedge clk);
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_wrap", wrap_cnt, 0);
      chk("mrst_q", w_cnt_q, 0);
      clear = 1'b1;
      @(negedge clk);
      exp_q    = 0;
      exp_wrap = 0;

      // Random command stream against the reference
      for (int t = 0; t < 40; t++) begin
         int r, op, n;
         r = $urandom_range(0, 9);
         if (r < 4)       begin op = OP_STEP; n = $urandom_range(0, 25); end
         else if (r < 7)  begin op = OP_RUN;  n = $urandom_range(1, 40); end
         else if (r == 7) begin op = OP_RESTART; n = 0; end
         else             begin op = OP_STOP; n = 0; end
         run_txn(op, n, adv, dn);
         model_txn(op, n, e_adv, e_dn);
         chk($sformatf("rnd%0d_op%0d_n%0d_adv", t, op, n), adv, e_adv);
         chk($sformatf("rnd%0d_op%0d_n%0d_done", t, op, n), dn, e_dn);
         chk($sformatf("rnd%0d_op%0d_n%0d_q", t, op, n), w_cnt_q, exp_q);
         chk($sformatf("rnd%0d_op%0d_n%0d_wrap", t, op, n), wrap_cnt, exp_wrap);
         if (op == OP_STEP) chk($sformatf("rnd%0d_step_ready", t), step_rdy, 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
